// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the five-stage MIPS pipeline. It detects load-use
// hazards, inserts bubbles, holds on downstream stalls, and counts inserted bubbles.
module id_ex_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_writereg,
  input  logic [31:0] id_data1,
  input  logic [31:0] id_data2,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_aluop,
  input  logic        id_regwre,
  input  logic        id_wrctr,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_link,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        cnt_clr,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_writereg,
  output logic [3:0]  ex_aluop,
  output logic        ex_regwre,
  output logic        ex_wrctr,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_link,
  output logic        stall_if_id,
  output logic        load_use,
  output logic [15:0] hazard_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  writereg;
    logic [3:0]  aluop;
    logic        regwre;
    logic        wrctr;
    logic        memread;
    logic        memwrite;
    logic        link;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [15:0] hazard_cnt_q, hazard_cnt_d;
  logic        rs_hit, rt_hit;

  // r0 is never a real producer, so a load targeting it cannot cause a hazard
  always_comb begin
    rs_hit      = id_uses_rs & (id_rs == ex_q.writereg);
    rt_hit      = id_uses_rt & (id_rt == ex_q.writereg);
    load_use    = id_valid & ex_q.valid & ex_q.memread & (ex_q.writereg != 5'd0) &
                  (rs_hit | rt_hit);
    stall_if_id = (load_use | ex_stall) & ~flush;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.data1    = id_data1;
      ex_d.data2    = id_data2;
      ex_d.imm      = id_imm;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.writereg = id_writereg;
      ex_d.aluop    = id_aluop;
      ex_d.regwre   = id_regwre   & id_valid;
      ex_d.wrctr    = id_wrctr    & id_valid;
      ex_d.memread  = id_memread  & id_valid;
      ex_d.memwrite = id_memwrite & id_valid;
      ex_d.link     = id_link     & id_valid;
    end
  end

  // Only bubbles that actually get inserted are counted; a flush or hold masks them
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (cnt_clr)
      hazard_cnt_d = 16'd0;
    else if (load_use && !flush && !ex_stall && hazard_cnt_q != 16'hFFFF)
      hazard_cnt_d = hazard_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      hazard_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_data1    = ex_q.data1;
  assign ex_data2    = ex_q.data2;
  assign ex_imm      = ex_q.imm;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_writereg = ex_q.writereg;
  assign ex_aluop    = ex_q.aluop;
  assign ex_regwre   = ex_q.regwre;
  assign ex_wrctr    = ex_q.wrctr;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_link     = ex_q.link;
  assign hazard_cnt  = hazard_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed and randomized bench for id_ex_pipe. It checks the DUT against a
// rule-level model of the ID/EX register and the bubble counter.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_regwre, id_wrctr, id_memread, id_memwrite, id_link;
  logic        id_uses_rs, id_uses_rt, flush, ex_stall, cnt_clr;
  logic [31:0] id_pc, id_data1, id_data2, id_imm;
  logic [4:0]  id_rs, id_rt, id_writereg;
  logic [3:0]  id_aluop;
  logic        ex_valid, ex_regwre, ex_wrctr, ex_memread, ex_memwrite, ex_link;
  logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_writereg;
  logic [3:0]  ex_aluop;
  logic        stall_if_id, load_use;
  logic [15:0] hazard_cnt;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs),
    .id_rt(id_rt), .id_writereg(id_writereg), .id_data1(id_data1), .id_data2(id_data2),
    .id_imm(id_imm), .id_aluop(id_aluop), .id_regwre(id_regwre), .id_wrctr(id_wrctr),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_link(id_link),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .flush(flush), .ex_stall(ex_stall),
    .cnt_clr(cnt_clr), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_writereg(ex_writereg), .ex_aluop(ex_aluop), .ex_regwre(ex_regwre),
    .ex_wrctr(ex_wrctr), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_link(ex_link), .stall_if_id(stall_if_id), .load_use(load_use),
    .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs, rt, wr;
    logic [3:0]  op;
    logic        regwre, wrctr, memread, memwrite, link;
  } mex_t;

  mex_t        m;
  logic [15:0] mcnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic mex_t bubble();
    mex_t b;
    b = '{v:1'b0, pc:32'd0, d1:32'd0, d2:32'd0, imm:32'd0, rs:5'd0, rt:5'd0, wr:5'd0,
          op:4'd0, regwre:1'b0, wrctr:1'b0, memread:1'b0, memwrite:1'b0, link:1'b0};
    return b;
  endfunction

  // Load in EX, nonzero destination, and a source the ID instruction really reads
  function automatic logic model_lu();
    return id_valid && m.v && m.memread && (m.wr != 5'd0) &&
           ((id_uses_rs && id_rs == m.wr) || (id_uses_rt && id_rt == m.wr));
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, ex_valid, m.v);
    chk({tag, ".pc"}, ex_pc, m.pc);
    chk({tag, ".d1"}, ex_data1, m.d1);
    chk({tag, ".d2"}, ex_data2, m.d2);
    chk({tag, ".imm"}, ex_imm, m.imm);
    chk({tag, ".rs"}, ex_rs, m.rs);
    chk({tag, ".rt"}, ex_rt, m.rt);
    chk({tag, ".wr"}, ex_writereg, m.wr);
    chk({tag, ".op"}, ex_aluop, m.op);
    chk({tag, ".ctl"}, {ex_regwre, ex_wrctr, ex_memread, ex_memwrite, ex_link},
        {m.regwre, m.wrctr, m.memread, m.memwrite, m.link});
    chk({tag, ".cnt"}, hazard_cnt, mcnt);
  endtask

  // One clock: check combinational outputs, advance the model, check registered state
  task automatic cyc(input string tag);
    logic        lu;
    mex_t        nx;
    logic [15:0] ncnt;
    #1;
    lu = model_lu();
    chk({tag, ".lu"}, load_use, lu);
    chk({tag, ".stall"}, stall_if_id, (lu || ex_stall) && !flush);
    if (flush)         nx = bubble();
    else if (ex_stall) nx = m;
    else if (lu)       nx = bubble();
    else
      nx = '{v:id_valid, pc:id_pc, d1:id_data1, d2:id_data2, imm:id_imm, rs:id_rs,
             rt:id_rt, wr:id_writereg, op:id_aluop, regwre:id_regwre && id_valid,
             wrctr:id_wrctr && id_valid, memread:id_memread && id_valid,
             memwrite:id_memwrite && id_valid, link:id_link && id_valid};
    ncnt = mcnt;
    if (cnt_clr) ncnt = 16'd0;
    else if (lu && !flush && !ex_stall && mcnt != 16'hFFFF) ncnt = mcnt + 16'd1;
    @(posedge clk);
    #1;
    m    = nx;
    mcnt = ncnt;
    check_ex(tag);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wr, input logic [31:0] d1,
                        input logic [31:0] d2, input logic mr, input logic urs,
                        input logic urt);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_writereg = wr;
    id_data1 = d1; id_data2 = d2; id_imm = pc ^ 32'h0000_ABCD; id_aluop = pc[3:0];
    id_regwre = 1'b1; id_wrctr = ~mr; id_memread = mr; id_memwrite = 1'b0;
    id_link = 1'b0; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  task automatic set_load(input logic [31:0] pc, input logic [4:0] wr);
    set_id(1'b1, pc, 5'd29, 5'd0, wr, 32'h1000_0000, 32'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_dep_rs(input logic [31:0] pc, input logic [4:0] rs);
    set_id(1'b1, pc, rs, 5'd3, 5'd10, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic set_random();
    id_valid = ($urandom_range(0, 9) != 0);
    id_pc = $urandom; id_data1 = $urandom; id_data2 = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_writereg = 5'($urandom_range(0, 3)); id_aluop = 4'($urandom);
    id_regwre = 1'($urandom); id_wrctr = 1'($urandom); id_memread = 1'($urandom);
    id_memwrite = 1'($urandom); id_link = 1'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    flush = ($urandom_range(0, 9) == 0);
    ex_stall = ($urandom_range(0, 6) == 0);
    cnt_clr = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0; cnt_clr = 1'b0;
    set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    m = bubble(); mcnt = 16'd0;
    #2;
    check_ex("reset0");
    chk("reset0.stall", stall_if_id, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Capture, then assert reset asynchronously between edges
    set_id(1'b1, 32'h0040_0010, 5'd1, 5'd2, 5'd4, 32'h7, 32'h8, 1'b0, 1'b1, 1'b1);
    cyc("cap");
    chk("cap.pc_const", ex_pc, 32'h0040_0010);
    #2 rst_n = 1'b0;
    #1;
    m = bubble(); mcnt = 16'd0;
    check_ex("async_rst");
    chk("async_rst.pc_const", ex_pc, 32'd0);
    chk("async_rst.lu", load_use, 1'b0);
    rst_n = 1'b1;

    // Normal pass
    set_id(1'b1, 32'h0040_0020, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1);
    id_wrctr = 1'b1;
    cyc("pass");
    chk("pass.pc_const", ex_pc, 32'h0040_0020);
    chk("pass.d1_const", ex_data1, 32'h11);
    chk("pass.d2_const", ex_data2, 32'h22);
    chk("pass.wr_const", ex_writereg, 5'd9);
    chk("pass.valid_const", ex_valid, 1'b1);

    // Load-use: bubble, count, then the dependent instruction enters EX
    set_load(32'h0040_0030, 5'd8);
    cyc("lw");
    set_dep_rs(32'h0040_0034, 5'd8);
    #1;
    chk("lu.detect", load_use, 1'b1);
    chk("lu.stall", stall_if_id, 1'b1);
    cyc("lu.bubble");
    chk("lu.bubble_valid", ex_valid, 1'b0);
    chk("lu.cnt_const", hazard_cnt, 16'd1);
    #1;
    chk("lu.after_stall", stall_if_id, 1'b0);
    cyc("lu.dep");
    chk("lu.dep_pc", ex_pc, 32'h0040_0034);

    // No false hazards: r0 destination, and unused rt
    set_load(32'h0040_0040, 5'd0);
    cyc("lw0");
    set_dep_rs(32'h0040_0044, 5'd0);
    #1;
    chk("r0.stall", stall_if_id, 1'b0);
    cyc("r0.next");
    set_load(32'h0040_0048, 5'd8);
    cyc("lw8");
    set_id(1'b1, 32'h0040_004C, 5'd3, 5'd8, 5'd10, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
    #1;
    chk("nort.stall", stall_if_id, 1'b0);
    cyc("nort.next");

    // Flush wins over the hazard and does not count
    set_load(32'h0040_0050, 5'd8);
    cyc("lw_f");
    set_dep_rs(32'h0040_0054, 5'd8);
    flush = 1'b1;
    cyc("flush");
    chk("flush.valid", ex_valid, 1'b0);
    chk("flush.cnt_const", hazard_cnt, 16'd1);
    flush = 1'b0;

    // Hold for 3 cycles with a hazard pending, then the bubble lands
    set_load(32'h0040_0060, 5'd8);
    cyc("lw_h");
    set_dep_rs(32'h0040_0064, 5'd8);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("hold");
      chk("hold.pc_const", ex_pc, 32'h0040_0060);
      chk("hold.cnt_const", hazard_cnt, 16'd1);
    end
    ex_stall = 1'b0;
    cyc("hold.release");
    chk("hold.cnt2", hazard_cnt, 16'd2);

    // Saturation: preload the counter near the top instead of 65k real hazards
    force dut.hazard_cnt_q = 16'hFFFA;
    #1;
    release dut.hazard_cnt_q;
    mcnt = 16'hFFFA;
    chk("sat.preload", hazard_cnt, 16'hFFFA);
    for (int i = 0; i < 8; i++) begin
      set_load(32'h0040_1000 + 32'(i * 8), 5'd8);
      cyc("sat.lw");
      set_dep_rs(32'h0040_1004 + 32'(i * 8), 5'd8);
      cyc("sat.bubble");
    end
    chk("sat.max", hazard_cnt, 16'hFFFF);
    set_load(32'h0040_2000, 5'd8);
    cyc("clr.lw");
    set_dep_rs(32'h0040_2004, 5'd8);
    cnt_clr = 1'b1;
    cyc("clr");
    chk("clr.zero", hazard_cnt, 16'd0);
    cnt_clr = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      set_random();
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
